// File: rtl/bar_pkg.sv
// Shared definitions for the bar controller: FSM states, HID keycodes,
// default screen geometry and a signed saturation helper.
package bar_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SAMPLE,
      ST_RESIZE,
      ST_MOVE,
      ST_CLAMP,
      ST_COMMIT
   } state_t;

   localparam logic [7:0] KEY_NONE  = 8'h00;
   localparam logic [7:0] KEY_W     = 8'h1A;
   localparam logic [7:0] KEY_S     = 8'h16;
   localparam logic [7:0] KEY_A     = 8'h04;
   localparam logic [7:0] KEY_D     = 8'h07;
   localparam logic [7:0] KEY_UP    = 8'h52;
   localparam logic [7:0] KEY_DOWN  = 8'h51;
   localparam logic [7:0] KEY_RIGHT = 8'h4F;
   localparam logic [7:0] KEY_LEFT  = 8'h50;

   localparam int DEF_X_MAX  = 639;
   localparam int DEF_Y_MAX  = 479;
   localparam int DEF_STEP   = 2;
   localparam int DEF_W_MIN  = 4;
   localparam int DEF_W_MAX  = 160;
   localparam int DEF_H_MIN  = 4;
   localparam int DEF_H_MAX  = 120;
   localparam int DEF_X_INIT = 320;
   localparam int DEF_Y_INIT = 240;
   localparam int DEF_W_INIT = 40;
   localparam int DEF_H_INIT = 8;

   // Working values are 11-bit signed so a move below zero stays negative.
   function automatic logic signed [10:0] sat11(input logic signed [10:0] v,
                                                input logic signed [10:0] lo,
                                                input logic signed [10:0] hi);
      if (v < lo)      return lo;
      else if (v > hi) return hi;
      else             return v;
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus rising-edge detector; a level that is already
// high when reset releases is not reported as an edge.
module sync_edge (
   input  logic Clk,
   input  logic Reset,
   input  logic i_async,
   output logic o_rise
);

   logic       r_meta;
   logic       r_sync;
   logic       r_prev;
   logic [2:0] r_vld;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
         r_vld  <= 3'b000;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
         r_prev <= r_sync;
         r_vld  <= {r_vld[1:0], 1'b1};
      end
   end

   // Edges are only trusted once the pipeline holds post-reset samples only.
   assign o_rise = r_sync & ~r_prev & r_vld[2];

endmodule

// File: rtl/bar_controller.sv
// Keyboard-driven bar geometry: one update per frame through a fixed
// SAMPLE/RESIZE/MOVE/CLAMP/COMMIT sequence, with a sticky missed-frame flag.
module bar_controller
   import bar_pkg::*;
#(
   parameter int X_MAX  = DEF_X_MAX,
   parameter int Y_MAX  = DEF_Y_MAX,
   parameter int STEP   = DEF_STEP,
   parameter int W_MIN  = DEF_W_MIN,
   parameter int W_MAX  = DEF_W_MAX,
   parameter int H_MIN  = DEF_H_MIN,
   parameter int H_MAX  = DEF_H_MAX,
   parameter int X_INIT = DEF_X_INIT,
   parameter int Y_INIT = DEF_Y_INIT,
   parameter int W_INIT = DEF_W_INIT,
   parameter int H_INIT = DEF_H_INIT
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic [7:0] keycode,
   output logic [9:0] BarX,
   output logic [9:0] BarY,
   output logic [9:0] BarW,
   output logic [9:0] BarH,
   output logic       busy,
   output logic       frame_miss
);

   localparam logic signed [10:0] C_X_MAX = 11'(X_MAX);
   localparam logic signed [10:0] C_Y_MAX = 11'(Y_MAX);
   localparam logic signed [10:0] C_STEP  = 11'(STEP);
   localparam logic signed [10:0] C_W_MIN = 11'(W_MIN);
   localparam logic signed [10:0] C_W_MAX = 11'(W_MAX);
   localparam logic signed [10:0] C_H_MIN = 11'(H_MIN);
   localparam logic signed [10:0] C_H_MAX = 11'(H_MAX);

   state_t                r_state;
   state_t                w_next;
   logic [7:0]            r_cmd;
   logic signed [10:0]    r_x, r_y, r_w, r_h;
   logic signed [10:0]    w_dx, w_dy, w_dw, w_dh;
   logic                  w_tick;

   sync_edge u_sync_edge (
      .Clk     (Clk),
      .Reset   (Reset),
      .i_async (frame_clk),
      .o_rise  (w_tick)
   );

   always_comb begin
      // NOTE: every comb output gets a default first so no latch is inferred.
      w_next = r_state;
      unique case (r_state)
         ST_IDLE:   if (w_tick) w_next = ST_SAMPLE;
         ST_SAMPLE: w_next = ST_RESIZE;
         ST_RESIZE: w_next = ST_MOVE;
         ST_MOVE:   w_next = ST_CLAMP;
         ST_CLAMP:  w_next = ST_COMMIT;
         ST_COMMIT: w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_dx = '0;
      w_dy = '0;
      w_dw = '0;
      w_dh = '0;
      case (r_cmd)
         KEY_W:     w_dy = -C_STEP;
         KEY_S:     w_dy = C_STEP;
         KEY_A:     w_dx = -C_STEP;
         KEY_D:     w_dx = C_STEP;
         KEY_UP:    w_dh = 11'sd1;
         KEY_DOWN:  w_dh = -11'sd1;
         KEY_RIGHT: w_dw = 11'sd1;
         KEY_LEFT:  w_dw = -11'sd1;
         default:   ;
      endcase
   end

   assign busy = (r_state != ST_IDLE);

   // NOTE: sequential state uses <= so each stage sees last cycle's values.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state    <= ST_IDLE;
         r_cmd      <= KEY_NONE;
         r_x        <= 11'(X_INIT);
         r_y        <= 11'(Y_INIT);
         r_w        <= 11'(W_INIT);
         r_h        <= 11'(H_INIT);
         BarX       <= 10'(X_INIT);
         BarY       <= 10'(Y_INIT);
         BarW       <= 10'(W_INIT);
         BarH       <= 10'(H_INIT);
         frame_miss <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_tick && busy) frame_miss <= 1'b1;
         case (r_state)
            ST_SAMPLE: begin
               r_cmd <= keycode;
               r_x   <= {1'b0, BarX};
               r_y   <= {1'b0, BarY};
               r_w   <= {1'b0, BarW};
               r_h   <= {1'b0, BarH};
            end
            ST_RESIZE: begin
               r_w <= sat11(r_w + w_dw, C_W_MIN, C_W_MAX);
               r_h <= sat11(r_h + w_dh, C_H_MIN, C_H_MAX);
            end
            ST_MOVE: begin
               r_x <= r_x + w_dx;
               r_y <= r_y + w_dy;
            end
            // Clamping against the resized W/H pushes the bar back on-screen;
            // the result lands on the outputs as the FSM enters COMMIT.
            ST_CLAMP: begin
               BarX <= 10'(sat11(r_x, r_w, C_X_MAX));
               BarY <= 10'(sat11(r_y, r_h, C_Y_MAX));
               BarW <= 10'(r_w);
               BarH <= 10'(r_h);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/bar_controller.md
BAR_CONTROLLER -- requirements
Module: bar_controller

Interface
REQ-001 Parameter X_MAX, default 639, rightmost legal BarX.
REQ-002 Parameter Y_MAX, default 479, bottom legal BarY.
REQ-003 Parameter STEP, default 2, pixels moved per frame per move command.
REQ-004 Parameter W_MIN / W_MAX, default 4 / 160, legal BarW range; H_MIN / H_MAX, default 4 / 120, legal BarH range.
REQ-005 Parameter X_INIT / Y_INIT / W_INIT / H_INIT, default 320 / 240 / 40 / 8, reset geometry.
REQ-006 Clk  input  1  single system clock; all state on rising edge.
REQ-007 Reset  input  1  synchronous, active-high.
REQ-008 frame_clk  input  1  vertical-sync pulse, asynchronous to Clk.
REQ-009 keycode  input  8  current USB HID keycode; 0x00 means no key.
REQ-010 BarX, BarY  output  10  bottom-right corner of bar, registered.
REQ-011 BarW, BarH  output  10  bar width/height, registered.
REQ-012 busy  output  1  high while an update is in progress (FSM not IDLE).
REQ-013 frame_miss  output  1  sticky; set when a frame edge arrives while busy.

Function
REQ-014 frame_clk SHALL pass a 2-flop synchronizer; a rising edge of the synchronized signal generates a one-cycle frame_tick.
REQ-015 FSM states: IDLE, SAMPLE, RESIZE, MOVE, CLAMP, COMMIT; each non-IDLE state lasts exactly one cycle.
REQ-016 IDLE -> SAMPLE on frame_tick; SAMPLE latches keycode into cmd register; then SAMPLE->RESIZE->MOVE->CLAMP->COMMIT->IDLE unconditionally.
REQ-017 Outputs SHALL change only in the COMMIT cycle; they update exactly 5 Clk cycles after frame_tick; between commits outputs are stable.
REQ-018 Commands: 0x1A (W) Y-=STEP; 0x16 (S) Y+=STEP; 0x04 (A) X-=STEP; 0x07 (D) X+=STEP; 0x52 (Up) H+=1; 0x51 (Down) H-=1; 0x4F (Right) W+=1; 0x50 (Left) W-=1; any other code: no change.
REQ-019 Working registers SHALL be 11-bit signed so underflow below 0 is detectable before clamping.
REQ-020 RESIZE: W,H saturate to [W_MIN,W_MAX] and [H_MIN,H_MAX].
REQ-021 CLAMP: X saturates to [W, X_MAX], Y to [H, Y_MAX], using post-resize W/H, so the bar never extends off-screen or wraps.
REQ-022 Resize at an edge SHALL push the position inward (e.g. X=W then W+=1 gives X=W+1).
REQ-023 frame_tick while busy SHALL be ignored for update purposes and SHALL set frame_miss; frame_miss clears only on Reset.
REQ-024 keycode changes after SAMPLE SHALL NOT affect the in-progress update.

Reset
REQ-025 On Reset: BarX=X_INIT, BarY=Y_INIT, BarW=W_INIT, BarH=H_INIT, busy=0, frame_miss=0, FSM=IDLE, synchronizer flops=0, cmd=0x00.
REQ-026 Reset asserted mid-update SHALL abort it; no COMMIT occurs and outputs take reset values on the next edge.
REQ-027 A frame_clk level already high at reset release SHALL NOT produce a frame_tick.

Structure
REQ-028 Package bar_pkg SHALL hold the FSM state enum, keycode constants and screen-limit defaults.
REQ-029 Sub-module sync_edge (2-flop synchronizer + rising-edge detector) SHALL produce frame_tick.
REQ-030 Arithmetic and FSM SHALL reside in bar_controller; no multipliers.

Verification
REQ-031 Reset, then one frame pulse with keycode=0x07 -> after 5 Clk from tick BarX=322, BarY=240, W=40, H=8; busy high for exactly 5 cycles.
REQ-032 keycode=0x04 held for 200 frames from reset -> BarX decrements by 2 per frame, saturates at 40, never lower.
REQ-033 W=160 via repeated 0x4F, one more 0x4F -> W stays 160; with X=40 and W=40, 0x50 -> W=39, X=40; 0x4F -> W=41, X=41.
REQ-034 Second frame_clk rising edge 2 cycles after the first -> only one update occurs, frame_miss=1 until Reset.
REQ-035 Reset asserted in the RESIZE state with keycode=0x52 -> no commit; outputs equal reset geometry; FSM IDLE.
REQ-036 keycode switched from 0x1A to 0x16 one cycle after SAMPLE -> committed BarY=238.
